// File: rtl/chngy_update_ctrl_if.sv
// chngy_update_ctrl_if: change-record handshake between the change-file reader (master) and the update sequencer (slave)
interface chngy_update_ctrl_if #(
   parameter int IDX_W = 5,
   parameter int DW = 48
);
   logic chg_valid;
   logic chg_ready;
   logic [IDX_W-1:0] chg_row;
   logic [IDX_W-1:0] chg_col;
   logic [DW-1:0] chg_delta;
   modport master (output chg_valid, chg_row, chg_col, chg_delta, input chg_ready);
   modport slave (input chg_valid, chg_row, chg_col, chg_delta, output chg_ready);
endinterface

// File: rtl/chngy_update_ctrl.sv
// chngy_update_ctrl: sequences one change-in-Y record through the Y RAM and the update datapath
module chngy_update_ctrl #(
   parameter int IDX_W = 5,
   parameter int DW = 48
) (
   input  logic clock,
   input  logic reset,
   chngy_update_ctrl_if.slave chg,
   output logic [2*IDX_W-1:0] y_addr,
   output logic y_we,
   output logic [DW-1:0] y_wdata,
   input  logic [DW-1:0] y_rdata,
   output logic dp_en,
   output logic [DW-1:0] dp_in1,
   output logic [DW-1:0] dp_in2,
   input  logic [DW-1:0] dp_out,
   input  logic dp_exdone,
   input  logic dp_done,
   input  logic dp_cpdone,
   output logic busy,
   output logic rec_done,
   output logic err,
   output logic [15:0] rec_count
);
   typedef enum logic [3:0] {
      IDLE, RD_OFF, WT_OFF, EX_OFF, WB_OFF1, WB_OFF2, RD_DI, WT_DI, EX_DI, WB_DI,
      RD_DJ, WT_DJ, EX_DJ, WB_DJ, DONE
   } stateT;
   stateT state, nextState;
   logic [IDX_W-1:0] row, col, rowN, colN;
   logic [DW-1:0] delta, yij, result;
   logic mismatch, accept, skipNow, mmNow;
   assign accept = state == IDLE && chg.chg_valid;
   assign skipNow = chg.chg_row == chg.chg_col || chg.chg_delta == '0;
   assign rowN = state == IDLE ? chg.chg_row : row;
   assign colN = state == IDLE ? chg.chg_col : col;
   assign mmNow = (state == WB_OFF1 && !(dp_exdone && !dp_done)) ||
                  (state == WB_DI && !(dp_exdone && dp_done && !dp_cpdone)) ||
                  (state == WB_DJ && !(dp_exdone && dp_done && dp_cpdone));
   // A zero Yij is only visible once latched, so the abort decision is taken in EX_OFF
   always_comb begin
      nextState = state == IDLE ? (accept ? (skipNow ? DONE : RD_OFF) : IDLE) :
                  state == DONE ? IDLE :
                  (state == EX_OFF && yij == '0) ? DONE : stateT'(state + 4'd1);
   end
   assign y_wdata = !y_we ? '0 : state == WB_OFF2 ? result : dp_out;
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= IDLE;
         row <= '0;
         col <= '0;
         delta <= '0;
         yij <= '0;
         result <= '0;
         mismatch <= 1'b0;
         y_addr <= '0;
         y_we <= 1'b0;
         dp_en <= 1'b0;
         dp_in1 <= '0;
         dp_in2 <= '0;
         busy <= 1'b0;
         chg.chg_ready <= 1'b1;
         rec_done <= 1'b0;
         err <= 1'b0;
         rec_count <= '0;
      end else begin
         state <= nextState;
         if (accept) begin
            row <= chg.chg_row;
            col <= chg.chg_col;
            delta <= chg.chg_delta;
         end
         if (state == WT_OFF) yij <= y_rdata;
         if (state == WB_OFF1) result <= dp_out;
         mismatch <= state == DONE ? 1'b0 : mismatch | mmNow;
         rec_count <= rec_count + {15'd0, state == DONE};
         // Outputs are registered from the next state so they line up with it
         y_addr <= nextState == WB_OFF2 ? {colN, rowN} :
                   nextState inside {RD_DI, WB_DI} ? {rowN, rowN} :
                   nextState inside {RD_DJ, WB_DJ} ? {colN, colN} :
                   nextState inside {RD_OFF, WB_OFF1} ? {rowN, colN} : '0;
         y_we <= nextState inside {WB_OFF1, WB_OFF2, WB_DI, WB_DJ};
         dp_en <= !(nextState inside {IDLE, DONE});
         dp_in1 <= nextState inside {EX_OFF, EX_DI, EX_DJ} ? y_rdata : '0;
         dp_in2 <= nextState == EX_OFF ? delta : '0;
         busy <= nextState != IDLE;
         chg.chg_ready <= nextState == IDLE;
         rec_done <= nextState == DONE;
         err <= nextState == DONE && (state == IDLE ? chg.chg_row == chg.chg_col :
                                      state == EX_OFF ? 1'b1 : mismatch | mmNow);
      end
   end
endmodule

// File: tb/tb_chngy_update_ctrl.sv
// tb_chngy_update_ctrl: randomized records against a record-level reference model with RAM and datapath stand-ins
module tb_chngy_update_ctrl;
   localparam int IW = 5;
   localparam int DW = 48;
   typedef struct { int cyc; logic [2*IW-1:0] addr; logic [DW-1:0] data; } wrT;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic [2*IW-1:0] y_addr;
   logic y_we, dp_en, busy, rec_done, err;
   logic [DW-1:0] y_wdata, y_rdata, dp_in1, dp_in2, dp_out;
   logic dp_exdone, dp_done, dpCp, dp_cpdone;
   logic [15:0] rec_count;
   logic [DW-1:0] mem [0:1023];
   logic ramInit = 1'b1, pokeEn = 1'b0, forceCpLow = 1'b0;
   logic [2*IW-1:0] pokeAddr = '0;
   logic [DW-1:0] pokeData = '0;
   int stepCnt;
   int checks = 0, passes = 0;
   wrT obsQ[$];

   chngy_update_ctrl_if #(.IDX_W(IW), .DW(DW)) chgIf ();

   chngy_update_ctrl #(.IDX_W(IW), .DW(DW)) dut (
      .clock(clock), .reset(reset), .chg(chgIf),
      .y_addr(y_addr), .y_we(y_we), .y_wdata(y_wdata), .y_rdata(y_rdata),
      .dp_en(dp_en), .dp_in1(dp_in1), .dp_in2(dp_in2), .dp_out(dp_out),
      .dp_exdone(dp_exdone), .dp_done(dp_done), .dp_cpdone(dp_cpdone),
      .busy(busy), .rec_done(rec_done), .err(err), .rec_count(rec_count)
   );

   always #5 clock = ~clock;

   function automatic logic [DW-1:0] dpf(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return (a ^ {b[DW-2:0], 1'b0}) | 48'h1;
   endfunction

   always @(posedge clock) begin
      if (ramInit) begin
         for (int k = 0; k < 1024; k++) mem[k] <= ((48'($urandom) << 16) ^ 48'($urandom)) | 48'h1;
      end else if (pokeEn) mem[pokeAddr] <= pokeData;
      else if (y_we) mem[y_addr] <= y_wdata;
      y_rdata <= mem[y_addr];
   end

   // Datapath stand-in: third valid operand set since enable raises completion
   always @(posedge clock) begin
      if (!dp_en) begin
         stepCnt <= 0; dp_out <= '0; dp_exdone <= 1'b0; dp_done <= 1'b0; dpCp <= 1'b0;
      end else if (dp_in1 != '0) begin
         dp_out <= dpf(dp_in1, dp_in2);
         dp_exdone <= 1'b1;
         dp_done <= stepCnt >= 1;
         dpCp <= stepCnt >= 2;
         stepCnt <= stepCnt + 1;
      end else dp_exdone <= 1'b0;
   end
   assign dp_cpdone = dpCp & !forceCpLow;

   task automatic poke(input logic [2*IW-1:0] a, input logic [DW-1:0] d);
      @(negedge clock); pokeAddr = a; pokeData = d; pokeEn = 1'b1;
      @(negedge clock); pokeEn = 1'b0;
   endtask

   task automatic run_and_check(input logic [IW-1:0] i, input logic [IW-1:0] j,
                                input logic [DW-1:0] d, input logic cpLow, input string tag);
      int expDone, doneCyc, errStray, viol;
      logic expErr, errAt;
      logic [DW-1:0] e1 [0:31];
      logic [DW-1:0] e2 [0:31];
      logic [15:0] cnt0;
      wrT expQ[$];
      for (int k = 0; k < 32; k++) begin e1[k] = '0; e2[k] = '0; end
      if (i == j) begin expDone = 1; expErr = 1'b1; end
      else if (d == '0) begin expDone = 1; expErr = 1'b0; end
      else if (mem[{i, j}] == '0) begin
         expDone = 4; expErr = 1'b1; e2[3] = d;
      end else begin
         expDone = 14; expErr = cpLow;
         e1[3] = mem[{i, j}]; e2[3] = d; e1[8] = mem[{i, i}]; e1[12] = mem[{j, j}];
         expQ.push_back('{4, {i, j}, dpf(mem[{i, j}], d)});
         expQ.push_back('{5, {j, i}, dpf(mem[{i, j}], d)});
         expQ.push_back('{9, {i, i}, dpf(mem[{i, i}], '0)});
         expQ.push_back('{13, {j, j}, dpf(mem[{j, j}], '0)});
      end
      cnt0 = rec_count;
      forceCpLow = cpLow;
      @(negedge clock);
      chgIf.chg_valid = 1'b1; chgIf.chg_row = i; chgIf.chg_col = j; chgIf.chg_delta = d;
      @(posedge clock); #1;
      chgIf.chg_valid = 1'b0; chgIf.chg_row = IW'($urandom); chgIf.chg_col = IW'($urandom);
      obsQ.delete(); doneCyc = -1; errAt = 1'b0; errStray = 0; viol = 0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clock);
         if (y_we) obsQ.push_back('{c, y_addr, y_wdata});
         if (busy !== 1'b1 || chgIf.chg_ready !== 1'b0 || dp_en !== (c < expDone) ||
             dp_in1 !== e1[c] || dp_in2 !== e2[c]) viol++;
         if (rec_done) begin doneCyc = c; errAt = err; break; end
         if (err) errStray++;
      end
      @(negedge clock);
      forceCpLow = 1'b0;
      checks++; if (doneCyc !== expDone) $display("FAIL %s done_cycle got %0d want %0d", tag, doneCyc, expDone); else passes++;
      checks++; if (errAt !== expErr) $display("FAIL %s err_at_done got %0b want %0b", tag, errAt, expErr); else passes++;
      checks++; if (errStray !== 0) $display("FAIL %s stray_err got %0d want 0", tag, errStray); else passes++;
      checks++; if (viol !== 0) $display("FAIL %s per_cycle_outputs bad_cycles %0d want 0", tag, viol); else passes++;
      checks++; if (obsQ.size() !== expQ.size()) $display("FAIL %s write_count got %0d want %0d", tag, obsQ.size(), expQ.size()); else passes++;
      for (int k = 0; k < expQ.size() && k < obsQ.size(); k++) begin
         checks++;
         if (obsQ[k].cyc !== expQ[k].cyc || obsQ[k].addr !== expQ[k].addr || obsQ[k].data !== expQ[k].data)
            $display("FAIL %s write%0d got c%0d a%h d%h want c%0d a%h d%h", tag, k, obsQ[k].cyc, obsQ[k].addr,
                     obsQ[k].data, expQ[k].cyc, expQ[k].addr, expQ[k].data);
         else passes++;
      end
      checks++; if (rec_count !== cnt0 + 16'd1) $display("FAIL %s rec_count got %0d want %0d", tag, rec_count, cnt0 + 16'd1); else passes++;
   endtask

   task automatic test_reset;
      chgIf.chg_valid = 1'b1; chgIf.chg_row = 5'd1; chgIf.chg_col = 5'd2; chgIf.chg_delta = 48'h123;
      repeat (3) @(negedge clock);
      ramInit = 1'b0;
      checks++; if ({chgIf.chg_ready, busy, y_we, dp_en, rec_done, err} !== 6'b100000)
         $display("FAIL reset_outputs got %b want 100000", {chgIf.chg_ready, busy, y_we, dp_en, rec_done, err}); else passes++;
      checks++; if (rec_count !== 16'd0) $display("FAIL reset_count got %0d want 0", rec_count); else passes++;
      checks++; if (y_addr !== '0 || dp_in1 !== '0 || dp_in2 !== '0 || y_wdata !== '0)
         $display("FAIL reset_buses got a%h i%h %h w%h want 0", y_addr, dp_in1, dp_in2, y_wdata); else passes++;
      chgIf.chg_valid = 1'b0; reset = 1'b1;
      @(negedge clock);
      checks++; if (busy !== 1'b0) $display("FAIL reset_no_accept busy got %b want 0", busy); else passes++;
   endtask

   task automatic test_reset_mid;
      logic [DW-1:0] jj;
      int wr;
      jj = mem[{5'd12, 5'd12}];
      @(negedge clock);
      chgIf.chg_valid = 1'b1; chgIf.chg_row = 5'd7; chgIf.chg_col = 5'd12; chgIf.chg_delta = 48'h55;
      @(posedge clock); #1 chgIf.chg_valid = 1'b0;
      repeat (9) @(negedge clock);
      checks++; if (y_we !== 1'b1 || y_addr !== {5'd7, 5'd7}) $display("FAIL mid_wb_di got we%b a%h want we1 a%h", y_we, y_addr, {5'd7, 5'd7}); else passes++;
      reset = 1'b0;
      @(negedge clock);
      checks++; if ({chgIf.chg_ready, busy, y_we, dp_en} !== 4'b1000)
         $display("FAIL mid_reset_idle got %b want 1000", {chgIf.chg_ready, busy, y_we, dp_en}); else passes++;
      reset = 1'b1; wr = 0;
      repeat (6) begin @(negedge clock); if (y_we) wr++; end
      checks++; if (wr !== 0) $display("FAIL mid_reset_writes got %0d want 0", wr); else passes++;
      checks++; if (mem[{5'd12, 5'd12}] !== jj) $display("FAIL mid_reset_yjj got %h want %h", mem[{5'd12, 5'd12}], jj); else passes++;
      checks++; if (rec_count !== 16'd0) $display("FAIL mid_reset_count got %0d want 0", rec_count); else passes++;
   endtask

   task automatic test_back_to_back;
      logic [15:0] cnt0;
      int doneCyc;
      cnt0 = rec_count;
      @(negedge clock);
      chgIf.chg_valid = 1'b1; chgIf.chg_row = 5'd3; chgIf.chg_col = 5'd3; chgIf.chg_delta = 48'h9;
      @(posedge clock); #1;
      chgIf.chg_row = 5'd1; chgIf.chg_col = 5'd6; chgIf.chg_delta = 48'h77;
      @(negedge clock);
      checks++; if (rec_done !== 1'b1) $display("FAIL b2b_first_done got %b want 1", rec_done); else passes++;
      @(negedge clock);
      checks++; if (chgIf.chg_ready !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_idle got rdy%b busy%b want 1 0", chgIf.chg_ready, busy); else passes++;
      @(posedge clock); #1 chgIf.chg_valid = 1'b0;
      doneCyc = -1;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clock);
         if (c == 1 && busy !== 1'b1) doneCyc = -2;
         if (rec_done) begin if (doneCyc == -1) doneCyc = c; break; end
      end
      checks++; if (doneCyc !== 14) $display("FAIL b2b_second_done got %0d want 14", doneCyc); else passes++;
      @(negedge clock);
      checks++; if (rec_count !== cnt0 + 16'd2) $display("FAIL b2b_count got %0d want %0d", rec_count, cnt0 + 16'd2); else passes++;
   endtask

   task automatic test_random;
      logic [IW-1:0] i, j;
      logic [DW-1:0] d;
      for (int n = 0; n < 40; n++) begin
         i = IW'($urandom); j = IW'($urandom);
         if ($urandom_range(0, 9) != 0) while (j == i) j = IW'($urandom);
         d = ($urandom_range(0, 9) == 0) ? '0 : (((48'($urandom) << 16) ^ 48'($urandom)) | 48'h2);
         if (i != j && $urandom_range(0, 9) == 0) poke({i, j}, '0);
         run_and_check(i, j, d, $urandom_range(0, 9) == 0, "random");
      end
   endtask

   initial begin
      chgIf.chg_valid = 1'b0; chgIf.chg_row = '0; chgIf.chg_col = '0; chgIf.chg_delta = '0;
      test_reset();
      test_reset_mid();
      run_and_check(5'd2, 5'd5, 48'h0000_1234_5678, 1'b0, "full_record");
      run_and_check(5'd3, 5'd3, 48'h42, 1'b0, "skip_diag");
      run_and_check(5'd6, 5'd9, 48'h0, 1'b0, "skip_zero_delta");
      poke({5'd1, 5'd4}, '0);
      run_and_check(5'd1, 5'd4, 48'h31, 1'b0, "zero_yij");
      test_back_to_back();
      run_and_check(5'd8, 5'd20, 48'hABC, 1'b1, "cpdone_fault");
      run_and_check(5'd20, 5'd8, 48'hDEF, 1'b0, "after_fault");
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
